// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths:
// receiver FSM state encoding, oversampling constants and the baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side bus of the UART receiver: read strobe, overrun clear,
// popped data, FIFO status and error pulses.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          rd_en;
    logic          overrun_clr;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    modport master (
        output rd_en, overrun_clr,
        input  rd_data, empty, full, count, frame_err, overrun, parity_err
    );

    modport slave (
        input  rd_en, overrun_clr,
        output rd_data, empty, full, count, frame_err, overrun, parity_err
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with registered read data and registered flags.
// A pop is accepted only when not empty; a push is accepted when not full,
// or when full and a pop is accepted on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_wr_ptr_nxt;
    logic [AW:0]      w_rd_ptr_nxt;
    logic [AW:0]      w_used_nxt;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_full;
    logic             r_empty;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop     = i_pop && !r_empty;
    assign w_do_push    = i_push && (!r_full || w_do_pop);
    assign w_wr_ptr_nxt = w_do_push ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_do_pop  ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
    assign w_used_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // Storage write; when full with a simultaneous pop the tail slot is the
    // head slot, and the read below still sees the old head value.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointers, read data and flags all update from the same next-pointer values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_count   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
            r_empty <= (w_used_nxt == '0);
            r_full  <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                       (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
            r_count <= CW'(w_used_nxt);
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop rx synchronizer, free-running 16x tick generator,
// frame FSM and receive FIFO with sticky overrun.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits;
// without it the frame is 8N1 and parity_err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low synchronized rx
// START     | counting to mid start bit; high there is a glitch
// DATA      | sampling 8 data bits LSB first, one every 16 ticks
// PARITY    | sampling the even-parity bit (parity build only)
// STOP      | sampling the stop bit; high pushes the byte and re-arms
// WAIT_HIGH | bad stop bit or break, waiting for the line to return high
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_fifo_if.slave bus
);
    import uart_pkg::*;

    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx;
    logic [DW-1:0] r_div_cnt;
    logic          w_tick;
    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [3:0]    r_smp_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          w_smp_due;
    logic          w_push;
    logic          w_frame_err;
    logic          r_frame_err;
    logic          r_overrun;
    logic          w_drop;
    logic [7:0]    w_rd_data;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bad;
    logic          w_parity_err;
    logic          r_parity_err;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // Oversample tick: down-counter, tick at terminal count zero, then reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= DW'(DIV - 1);
        end else begin
            r_div_cnt <= r_div_cnt - DW'(1);
        end
    end

    assign w_tick    = (r_div_cnt == '0);
    assign w_smp_due = w_tick && (r_smp_cnt == 4'd0);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (!w_rx) w_state_nxt = START;
            START:     if (w_smp_due) w_state_nxt = w_rx ? IDLE : DATA;
            DATA: begin
                if (w_smp_due && (r_bit_cnt == 3'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (w_smp_due) w_state_nxt = STOP;
`else
            PARITY:    w_state_nxt = IDLE;
`endif
            STOP:      if (w_smp_due) w_state_nxt = w_rx ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (w_rx) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: push and error strobes at the mid-bit decisions.
    always_comb begin
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_err = 1'b0;
`endif
        case (r_state)
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_smp_due) w_parity_err = w_rx ^ (^r_shift);
            end
`endif
            STOP: begin
                if (w_smp_due) begin
`ifdef UART_RX_PARITY_EN
                    w_push = w_rx && !r_par_bad;
`else
                    w_push = w_rx;
`endif
                    w_frame_err = !w_rx;
                end
            end
            default: ;
        endcase
    end

    // Sample-position down-counter, bit counter and LSB-first shift register.
    // IDLE preloads the counter so the first decision lands mid start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE) begin
                r_smp_cnt <= 4'(MID_SAMPLE);
            end else if (w_tick) begin
                r_smp_cnt <= (r_smp_cnt == 4'd0) ? 4'(OVERSAMPLE - 1) : r_smp_cnt - 4'd1;
            end
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_smp_due) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == IDLE) begin
                r_par_bad <= 1'b0;
            end else if ((r_state == PARITY) && w_smp_due) begin
                r_par_bad <= w_rx ^ (^r_shift);
            end
`endif
        end
    end

    // Registered error pulses, one cycle each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (bus.rd_en),
        .o_rd_data   (w_rd_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // A full FIFO only drops the byte when no read frees a slot on the same edge.
    assign w_drop = w_push && w_full && !bus.rd_en;

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.rd_data   = w_rd_data;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = w_count;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are generated at the
// bit level and received bytes are compared against a queue model.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 7372800;
    localparam int BAUD     = 115200;
    localparam int OVS      = 16;
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int BIT      = DIV * OVS;
`ifdef UART_RX_PARITY_EN
    localparam int BITS_BEFORE_STOP = 10;
`else
    localparam int BITS_BEFORE_STOP = 9;
`endif
    localparam int STOP_TICK = 7 + 16 * BITS_BEFORE_STOP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int cyc    = 0;

    byte unsigned q[$];
    logic [7:0]   m_rd  = 8'h00;
    logic         m_ovr = 1'b0;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.parity_err === 1'b1) pe_cnt++;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_bad);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ par_bad, BIT);
`endif
        hold(stop_v, BIT);
        if (stop_v && !par_bad) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic pulse_read();
        @(negedge clk) bus.rd_en = 1'b1;
        @(negedge clk) bus.rd_en = 1'b0;
        if (q.size() > 0) m_rd = q.pop_front();
    endtask

    task automatic test_reset();
        int fe0;
        rst = 1'b1; rx = 1'b1; bus.rd_en = 1'b0; bus.overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h want 0", bus.rd_data); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); end
        rst = 1'b0;
        q.delete(); m_rd = 8'h00; m_ovr = 1'b0;
        fe0 = fe_cnt;
        hold(1'b1, 2 * BIT);
        hold(1'b0, 3 * BIT);
        rst = 1'b1;
        hold(1'b1, 4);
        rst = 1'b0;
        hold(1'b1, 12 * BIT);
        checks++; if (int'(bus.count) !== 0) begin errors++; $display("FAIL reset_midframe_count: got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_midframe_empty: got %b want 1", bus.empty); end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL reset_midframe_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    endtask

    task automatic test_loopback();
        logic [7:0] lb [4];
        lb[0] = 8'h41; lb[1] = 8'h42; lb[2] = 8'h43; lb[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            send_frame(lb[i], 1'b1, 1'b0);
            hold(1'b1, 8);
            checks++; if (int'(bus.count) !== q.size()) begin errors++; $display("FAIL loopback_count: got %0d want %0d", bus.count, q.size()); end
        end
        for (int i = 0; i < 4; i++) begin
            pulse_read();
            checks++; if (bus.rd_data !== lb[i]) begin errors++; $display("FAIL loopback_data: got %0h want %0h", bus.rd_data, lb[i]); end
            checks++; if (int'(bus.count) !== 3 - i) begin errors++; $display("FAIL loopback_read_count: got %0d want %0d", bus.count, 3 - i); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL loopback_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int fe0;
        fe0 = fe_cnt;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0);
            hold(1'b1, $urandom_range(0, BIT));
            checks++; if (int'(bus.count) !== q.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", bus.count, q.size()); end
            if ($urandom_range(0, 1) == 1) begin
                pulse_read();
                checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL random_data: got %0h want %0h", bus.rd_data, m_rd); end
                checks++; if (bus.empty !== (q.size() == 0)) begin errors++; $display("FAIL random_empty: got %b want %b", bus.empty, q.size() == 0); end
            end
        end
        while (q.size() > 0) begin
            pulse_read();
            checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL random_drain_data: got %0h want %0h", bus.rd_data, m_rd); end
            checks++; if (int'(bus.count) !== q.size()) begin errors++; $display("FAIL random_drain_count: got %0d want %0d", bus.count, q.size()); end
        end
        pulse_read();
        checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL read_empty_hold: got %0h want %0h", bus.rd_data, m_rd); end
        checks++; if (bus.empty !== 1'b1 || int'(bus.count) !== 0) begin errors++; $display("FAIL read_empty_flags: got empty=%b count=%0d want 1/0", bus.empty, bus.count); end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL random_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int fe0, pe0;
        logic [7:0] b;
        fe0 = fe_cnt; pe0 = pe_cnt;
        hold(1'b0, 14);
        hold(1'b1, 2 * BIT);
        checks++; if (int'(bus.count) !== 0 || bus.empty !== 1'b1) begin errors++; $display("FAIL glitch_fifo: got count=%0d empty=%b want 0/1", bus.count, bus.empty); end
        checks++; if (fe_cnt !== fe0 || pe_cnt !== pe0) begin errors++; $display("FAIL glitch_errors: got fe=%0d pe=%0d pulses want 0/0", fe_cnt - fe0, pe_cnt - pe0); end
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        hold(1'b1, 8);
        pulse_read();
        checks++; if (bus.rd_data !== b) begin errors++; $display("FAIL glitch_recover: got %0h want %0h", bus.rd_data, b); end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        hold(1'b0, 5 * BIT);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0); end
        checks++; if (int'(bus.count) !== q.size() || bus.empty !== 1'b1) begin errors++; $display("FAIL frame_err_fifo: got count=%0d empty=%b want 0/1", bus.count, bus.empty); end
        hold(1'b1, 2 * BIT);
        send_frame(8'hA5, 1'b1, 1'b0);
        hold(1'b1, 8);
        checks++; if (int'(bus.count) !== 1) begin errors++; $display("FAIL frame_err_next_count: got %0d want 1", bus.count); end
        pulse_read();
        checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL frame_err_next_data: got %0h want a5", bus.rd_data); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frame_err_extra: got %0d pulses want 1", fe_cnt - fe0); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            hold(1'b1, 4);
            checks++; if (int'(bus.count) !== q.size()) begin errors++; $display("FAIL overrun_count: got %0d want %0d", bus.count, q.size()); end
            checks++; if (bus.full !== (q.size() == DEPTH)) begin errors++; $display("FAIL overrun_full: got %b want %b", bus.full, q.size() == DEPTH); end
            checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL overrun_flag: got %b want %b after byte %0d", bus.overrun, m_ovr, i); end
        end
        for (int i = 0; i < 16; i++) begin
            pulse_read();
            checks++; if (bus.rd_data !== 8'(i)) begin errors++; $display("FAIL overrun_data: got %0h want %0h", bus.rd_data, i); end
        end
        checks++; if (bus.empty !== 1'b1 || bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got empty=%b overrun=%b want 1/1", bus.empty, bus.overrun); end
        @(negedge clk) bus.overrun_clr = 1'b1;
        @(negedge clk) bus.overrun_clr = 1'b0;
        m_ovr = 1'b0;
        checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
    endtask

    task automatic test_full_simul_read();
        logic [7:0] b17;
        logic [7:0] first;
        int p_start, t1, p_push;
        bit hit;
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        hold(1'b1, 4);
        first = q[0];
        checks++; if (int'(bus.count) !== DEPTH || bus.full !== 1'b1) begin errors++; $display("FAIL simul_fill: got count=%0d full=%b want 16/1", bus.count, bus.full); end
        b17 = 8'($urandom);
        hit = 1'b0;
        fork
            send_frame(b17, 1'b1, 1'b0);
            begin
                // rx low seen after 2 sync flops; START entered one edge later;
                // mid-stop decision lands on tick number STOP_TICK after that.
                p_start = cyc + 2;
                t1      = ((p_start / DIV) + 1) * DIV;
                p_push  = t1 + STOP_TICK * DIV;
                for (int k = 0; k < 16 * BIT && cyc < p_push; k++) @(negedge clk);
                if (cyc == p_push) begin
                    hit = 1'b1;
                    bus.rd_en = 1'b1;
                    @(negedge clk) bus.rd_en = 1'b0;
                    m_rd = q.pop_front();
                end
            end
        join
        hold(1'b1, 4);
        checks++; if (!hit) begin errors++; $display("FAIL simul_timing: got no read slot want read at edge %0d", p_push); end
        checks++; if (int'(bus.count) !== DEPTH) begin errors++; $display("FAIL simul_count: got %0d want %0d", bus.count, DEPTH); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus.rd_data !== first) begin errors++; $display("FAIL simul_rd_data: got %0h want %0h", bus.rd_data, first); end
        while (q.size() > 0) begin
            pulse_read();
            checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL simul_drain: got %0h want %0h", bus.rd_data, m_rd); end
        end
        checks++; if (bus.rd_data !== b17 || bus.empty !== 1'b1) begin errors++; $display("FAIL simul_tail: got %0h empty=%b want %0h/1", bus.rd_data, bus.empty, b17); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0;
        pe0 = pe_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        hold(1'b1, 4);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_bad_pulse: got %0d want 1", pe_cnt - pe0); end
        checks++; if (int'(bus.count) !== 0) begin errors++; $display("FAIL parity_bad_drop: got count=%0d want 0", bus.count); end
        send_frame(8'h03, 1'b1, 1'b0);
        hold(1'b1, 4);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_good_pulse: got %0d want 1", pe_cnt - pe0); end
        checks++; if (int'(bus.count) !== 1) begin errors++; $display("FAIL parity_good_count: got %0d want 1", bus.count); end
        pulse_read();
        checks++; if (bus.rd_data !== 8'h03) begin errors++; $display("FAIL parity_good_data: got %0h want 03", bus.rd_data); end
    endtask
`else
    task automatic test_parity();
        checks++; if (pe_cnt !== 0 || bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_tied: got %0d pulses want 0", pe_cnt); end
    endtask
`endif

    initial begin
        bus.rd_en = 1'b0;
        bus.overrun_clr = 1'b0;
        test_reset();
        test_loopback();
        test_random();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_simul_read();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
